// File: rtl/score_scroll_view_pkg.sv
// -----------------------------------------------------------------------------
// score_view_pkg
// Shared definitions for the end-of-game score scroll view:
//   - state_e        : view state (IDLE, SHOW, WIN)
//   - BLANK_CODE     : per-digit code the downstream decoder renders as blank
//   - SCORE_DISP_MAX : largest score the two score digits can show
//   - split_score()  : saturates a score and splits it into {tens, units}
// -----------------------------------------------------------------------------
package score_view_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_WIN  = 2'd2
  } state_e;

  localparam logic [3:0]  BLANK_CODE     = 4'hF;
  localparam int unsigned SCORE_DISP_MAX = 99;

  // Width of the score argument of split_score; callers zero-extend into it.
  localparam int SCORE_IN_W = 16;

  // Saturate at SCORE_DISP_MAX, return {tens, units} as two BCD nibbles.
  function automatic logic [7:0] split_score(input logic [SCORE_IN_W-1:0] score);
    logic [SCORE_IN_W-1:0] sat;
    logic [3:0]            tens;
    logic [3:0]            units;
    if (score > SCORE_IN_W'(SCORE_DISP_MAX)) begin
      sat = SCORE_IN_W'(SCORE_DISP_MAX);
    end else begin
      sat = score;
    end
    tens  = 4'(sat / SCORE_IN_W'(10));
    units = 4'(sat % SCORE_IN_W'(10));
    return {tens, units};
  endfunction

endpackage

// File: rtl/score_scroll_view_step_timer.sv
// -----------------------------------------------------------------------------
// step_timer
// Free-running 0..STEP_CYCLES-1 counter that emits a one-cycle step pulse on
// its terminal count and wraps to 0 in that same cycle.
// Ports:
//   clk    in  : clock
//   rst    in  : synchronous active-high reset
//   i_clr  in  : synchronous clear (count forced to 0)
//   i_en   in  : count enable
//   o_step out : high for the cycle in which the count sits at STEP_CYCLES-1
// -----------------------------------------------------------------------------
module step_timer #(
  parameter int STEP_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_step
);

  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Step counter: clears on reset/clear, wraps at the terminal count.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (r_cnt == TERM) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_step = i_en && (r_cnt == TERM);

endmodule

// File: rtl/score_scroll_view.sv
// -----------------------------------------------------------------------------
// score_scroll_view
// End-of-game results view for the seven-segment row. While `view` equals
// VIEW_ID it scrolls a 4-digit frame [player][blank][tens][units] from digit 0
// to digit NUM_DIGITS-4 for each active player in turn, then holds the
// winner's frame at the right edge (WIN). With LOOP=1 the sequence restarts
// after WIN_HOLD_STEPS steps. Outputs are hex codes per digit (4'hF = blank).
//
// Optional feature macro: SCORE_VIEW_BLINK_EN
//   defined   : WIN frame alternates visible/blank every 5 steps, visible first
//   undefined : WIN frame is steady
//
// Ports:
//   clk          in  : clock
//   rst          in  : synchronous active-high reset
//   view         in  : selected view; this block is active when == VIEW_ID
//   player_count in  : active players (0 treated as 1, clamped to MAX_PLAYERS)
//   scores       in  : player p (1-based) at [(p-1)*SCORE_W +: SCORE_W]
//   winner       in  : winning player, 1-based; out of range -> blank WIN frame
//   disp_code    out : digit i (0 = leftmost) at [4i+3:4i]
//   cur_player   out : player being scrolled; 0 in IDLE; last player in WIN
//   busy         out : high while scrolling (SHOW)
//   done         out : one-cycle pulse with the first WIN frame
// -----------------------------------------------------------------------------
module score_scroll_view
  import score_view_pkg::*;
#(
  parameter int MAX_PLAYERS    = 4,
  parameter int SCORE_W        = 7,
  parameter int NUM_DIGITS     = 8,
  parameter int STEP_CYCLES    = 10_000_000,
  parameter int VIEW_ID        = 2,
  parameter int LOOP           = 0,
  parameter int WIN_HOLD_STEPS = 30
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [2:0]                     view,
  input  logic [2:0]                     player_count,
  input  logic [MAX_PLAYERS*SCORE_W-1:0] scores,
  input  logic [2:0]                     winner,
  output logic [4*NUM_DIGITS-1:0]        disp_code,
  output logic [2:0]                     cur_player,
  output logic                           busy,
  output logic                           done
);

  localparam int POS_W = $clog2(NUM_DIGITS);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_DIGITS - 4);
  localparam int HOLD_W = (WIN_HOLD_STEPS > 1) ? $clog2(WIN_HOLD_STEPS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WIN_HOLD_STEPS - 1);

  // Pick player p's score (1-based) off the packed bus; 0 if p is out of range.
  function automatic logic [SCORE_W-1:0] score_of(
    input logic [MAX_PLAYERS*SCORE_W-1:0] bus,
    input logic [2:0]                     p
  );
    logic [SCORE_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_PLAYERS; i++) begin
      if (int'({29'd0, p}) == i + 1) begin
        v = bus[i*SCORE_W +: SCORE_W];
      end
    end
    return v;
  endfunction

  state_e              r_state;
  logic [POS_W-1:0]    r_pos;
  logic [2:0]          r_cur;
  logic [SCORE_W-1:0]  r_score;
  logic [2:0]          r_win_idx;
  logic                r_win_valid;
  logic                r_win_new;
  logic [HOLD_W-1:0]   r_hold;

  logic                w_view_on;
  logic                w_step;
  logic [2:0]          w_eff;
  logic                w_win_ok;
  logic                w_frame_vis;
  logic [4*NUM_DIGITS-1:0] w_disp;
  logic [7:0]          w_tu;
  logic                w_show_frame;
  logic [3:0]          w_idx_code;
  logic [POS_W-1:0]    w_fpos;

  assign w_view_on = (view == 3'(VIEW_ID));

  // Clamp the player count into 1..MAX_PLAYERS.
  always_comb begin
    if (player_count == 3'd0) begin
      w_eff = 3'd1;
    end else if (int'({29'd0, player_count}) > MAX_PLAYERS) begin
      w_eff = 3'(MAX_PLAYERS);
    end else begin
      w_eff = player_count;
    end
  end

  assign w_win_ok = (winner != 3'd0) && (winner <= w_eff);

  // Counter is held at 0 in IDLE and on the edge that leaves the view, so
  // every entry into SHOW starts a fresh step.
  step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_step_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr ((r_state == ST_IDLE) || !w_view_on),
    .i_en  (r_state != ST_IDLE),
    .o_step(w_step)
  );

  // Sequencing FSM: scroll position, current player and latched scores.
  always_ff @(posedge clk) begin
    r_win_new <= 1'b0;
    if (rst || !w_view_on) begin
      r_state     <= ST_IDLE;
      r_pos       <= '0;
      r_cur       <= 3'd0;
      r_score     <= '0;
      r_win_idx   <= 3'd0;
      r_win_valid <= 1'b0;
      r_hold      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_SHOW;
          r_cur   <= 3'd1;
          r_pos   <= '0;
          r_score <= score_of(scores, 3'd1);
        end
        ST_SHOW: begin
          if (w_step) begin
            if (r_pos == LAST_POS) begin
              // >= keeps the sequence finite if player_count drops mid-show.
              if (r_cur >= w_eff) begin
                r_state     <= ST_WIN;
                r_win_new   <= 1'b1;
                r_win_idx   <= winner;
                r_win_valid <= w_win_ok;
                r_score     <= w_win_ok ? score_of(scores, winner) : '0;
                r_hold      <= '0;
              end else begin
                r_cur   <= r_cur + 3'd1;
                r_pos   <= '0;
                r_score <= score_of(scores, r_cur + 3'd1);
              end
            end else begin
              r_pos <= r_pos + POS_W'(1);
            end
          end
        end
        ST_WIN: begin
          if ((LOOP != 0) && w_step) begin
            if (r_hold == HOLD_LAST) begin
              r_state <= ST_SHOW;
              r_cur   <= 3'd1;
              r_pos   <= '0;
              r_score <= score_of(scores, 3'd1);
              r_hold  <= '0;
            end else begin
              r_hold <= r_hold + HOLD_W'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SCORE_VIEW_BLINK_EN
  logic [2:0] r_blink_cnt;
  logic       r_blink_vis;

  // Blink phase: restarts visible on every WIN entry, toggles every 5 steps.
  always_ff @(posedge clk) begin
    if (rst || !w_view_on || (r_state != ST_WIN)) begin
      r_blink_cnt <= 3'd0;
      r_blink_vis <= 1'b1;
    end else if (w_step) begin
      if (r_blink_cnt == 3'd4) begin
        r_blink_cnt <= 3'd0;
        r_blink_vis <= ~r_blink_vis;
      end else begin
        r_blink_cnt <= r_blink_cnt + 3'd1;
      end
    end
  end

  assign w_frame_vis = r_blink_vis;
`else
  assign w_frame_vis = 1'b1;
`endif

  // Frame composition: place [idx][blank][tens][units] at w_fpos, rest blank.
  always_comb begin
    w_disp       = {NUM_DIGITS{BLANK_CODE}};
    w_tu         = split_score(SCORE_IN_W'(r_score));
    w_show_frame = 1'b0;
    w_idx_code   = BLANK_CODE;
    w_fpos       = r_pos;
    case (r_state)
      ST_SHOW: begin
        w_show_frame = 1'b1;
        w_idx_code   = {1'b0, r_cur};
        w_fpos       = r_pos;
      end
      ST_WIN: begin
        w_show_frame = r_win_valid && w_frame_vis;
        w_idx_code   = {1'b0, r_win_idx};
        w_fpos       = LAST_POS;
      end
      default: begin
        w_show_frame = 1'b0;
        w_idx_code   = BLANK_CODE;
        w_fpos       = '0;
      end
    endcase
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!w_show_frame) begin
        w_disp[4*i +: 4] = BLANK_CODE;
      end else if (i == int'(w_fpos)) begin
        w_disp[4*i +: 4] = w_idx_code;
      end else if (i == int'(w_fpos) + 2) begin
        w_disp[4*i +: 4] = w_tu[7:4];
      end else if (i == int'(w_fpos) + 3) begin
        w_disp[4*i +: 4] = w_tu[3:0];
      end else begin
        w_disp[4*i +: 4] = BLANK_CODE;
      end
    end
  end

  // Output register; leaving the view or reset blanks the outputs on the very
  // next edge rather than waiting for the state to reach IDLE first.
  always_ff @(posedge clk) begin
    if (rst || !w_view_on) begin
      disp_code  <= {NUM_DIGITS{BLANK_CODE}};
      cur_player <= 3'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      disp_code  <= w_disp;
      cur_player <= (r_state == ST_IDLE) ? 3'd0 : r_cur;
      busy       <= (r_state == ST_SHOW);
      done       <= r_win_new;
    end
  end

endmodule

// File: tb/tb_score_scroll_view.sv
// -----------------------------------------------------------------------------
// tb_score_scroll_view
// Self-checking bench for score_scroll_view (STEP_CYCLES=4, NUM_DIGITS=8).
// A LOOP=0 instance carries most scenarios; a LOOP=1, WIN_HOLD_STEPS=2
// instance covers the restart loop. Expected outputs come from a timeline
// model: sample k (k=0 is the first visible frame) maps to player/position by
// division, then WIN, then (looping) the sequence again.
// -----------------------------------------------------------------------------
module tb_score_scroll_view;

  localparam int STEP   = 4;
  localparam int HOLD_L = 2;

  logic        clk;
  logic        rst_m, rst_l;
  logic [2:0]  view_m, view_l;
  logic [2:0]  player_count;
  logic [27:0] scores;
  logic [2:0]  winner;
  logic [31:0] disp_m, disp_l;
  logic [2:0]  cur_m, cur_l;
  logic        busy_m, busy_l, done_m, done_l;
  logic [36:0] obs_m, obs_l;

  int n_cmp;
  int n_fail;
  int cfg_pc;
  int cfg_sc[4];
  int cfg_win;

  localparam logic [36:0] IDLE_VEC = {32'hFFFF_FFFF, 3'd0, 1'b0, 1'b0};

  score_scroll_view #(
    .MAX_PLAYERS(4), .SCORE_W(7), .NUM_DIGITS(8), .STEP_CYCLES(STEP),
    .VIEW_ID(2), .LOOP(0), .WIN_HOLD_STEPS(30)
  ) dut (
    .clk(clk), .rst(rst_m), .view(view_m), .player_count(player_count),
    .scores(scores), .winner(winner), .disp_code(disp_m),
    .cur_player(cur_m), .busy(busy_m), .done(done_m)
  );

  score_scroll_view #(
    .MAX_PLAYERS(4), .SCORE_W(7), .NUM_DIGITS(8), .STEP_CYCLES(STEP),
    .VIEW_ID(2), .LOOP(1), .WIN_HOLD_STEPS(HOLD_L)
  ) dut_loop (
    .clk(clk), .rst(rst_l), .view(view_l), .player_count(player_count),
    .scores(scores), .winner(winner), .disp_code(disp_l),
    .cur_player(cur_l), .busy(busy_l), .done(done_l)
  );

  assign obs_m = {disp_m, cur_m, busy_m, done_m};
  assign obs_l = {disp_l, cur_l, busy_l, done_l};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int s);
    return (s > 99) ? 99 : s;
  endfunction

  task automatic set_cfg(input int pc, input int s0, input int s1, input int s2,
                         input int s3, input int w);
    cfg_pc = pc;
    cfg_sc[0] = s0; cfg_sc[1] = s1; cfg_sc[2] = s2; cfg_sc[3] = s3;
    cfg_win = w;
    player_count = 3'(pc);
    winner = 3'(w);
    scores = {7'(s3), 7'(s2), 7'(s1), 7'(s0)};
  endtask

  // Expected {disp, cur, busy, done} for sample k after the view was entered.
  task automatic model(input int k, input bit lp, output logic [36:0] v);
    int eff, seg, show_len, kk, p, pos, s, wk;
    int d[8];
    bit vis;
    logic [31:0] disp;
    logic [2:0] cur;
    logic bz, dn;
    eff = (cfg_pc == 0) ? 1 : ((cfg_pc > 4) ? 4 : cfg_pc);
    seg = 5 * STEP;
    show_len = eff * seg;
    kk = lp ? (k % (show_len + HOLD_L * STEP)) : k;
    foreach (d[i]) d[i] = 15;
    dn = 1'b0;
    if (kk < show_len) begin
      p = kk / seg;
      pos = (kk % seg) / STEP;
      s = sat(cfg_sc[p]);
      d[pos] = p + 1;
      d[pos + 2] = s / 10;
      d[pos + 3] = s % 10;
      cur = 3'(p + 1);
      bz = 1'b1;
    end else begin
      wk = kk - show_len;
      cur = 3'(eff);
      bz = 1'b0;
      dn = (wk == 0);
      vis = 1'b1;
`ifdef SCORE_VIEW_BLINK_EN
      vis = ((wk / (5 * STEP)) % 2) == 0;
`endif
      if (vis && cfg_win >= 1 && cfg_win <= eff) begin
        s = sat(cfg_sc[cfg_win - 1]);
        d[4] = cfg_win;
        d[6] = s / 10;
        d[7] = s % 10;
      end
    end
    for (int i = 0; i < 8; i++) disp[4*i +: 4] = 4'(d[i]);
    v = {disp, cur, bz, dn};
  endtask

  task automatic test_reset();
    rst_m = 1'b1; rst_l = 1'b1; view_m = 3'd2; view_l = 3'd2;
    tick(); tick();
    n_cmp++;
    if (obs_m !== IDLE_VEC) begin
      n_fail++; $display("FAIL reset_main got %h want %h", obs_m, IDLE_VEC);
    end
    n_cmp++;
    if (obs_l !== IDLE_VEC) begin
      n_fail++; $display("FAIL reset_loop got %h want %h", obs_l, IDLE_VEC);
    end
    rst_m = 1'b0; rst_l = 1'b0; view_m = 3'd0; view_l = 3'd0;
    tick();
  endtask

  task automatic test_positions();
    logic [36:0] exp_v;
    int dones;
    dones = 0;
    set_cfg(2, 37, 5, 0, 0, 1);
    view_m = 3'd2;
    tick();
    n_cmp++;
    if (obs_m !== IDLE_VEC) begin
      n_fail++; $display("FAIL pos_startup got %h want %h", obs_m, IDLE_VEC);
    end
    for (int k = 0; k < 90; k++) begin
      tick();
      model(k, 1'b0, exp_v);
      if (done_m) dones++;
      n_cmp++;
      if (obs_m !== exp_v) begin
        n_fail++; $display("FAIL positions k=%0d got %h want %h", k, obs_m, exp_v);
      end
      // Scores change mid-frame; the latched value must stay in use.
      if (k == 5) scores = 28'($urandom);
      if (k == 11) set_cfg(2, 37, 5, 0, 0, 1);
    end
    n_cmp++;
    if (dones !== 1) begin
      n_fail++; $display("FAIL done_count got %0d want 1", dones);
    end
    view_m = 3'd0;
    tick();
  endtask

  task automatic test_saturation_clamp();
    logic [36:0] exp_v;
    set_cfg(0, 120, 50, 60, 70, 1);
    view_m = 3'd2;
    tick();
    for (int k = 0; k < 50; k++) begin
      tick();
      model(k, 1'b0, exp_v);
      n_cmp++;
      if (obs_m !== exp_v) begin
        n_fail++; $display("FAIL sat_clamp k=%0d got %h want %h", k, obs_m, exp_v);
      end
    end
    view_m = 3'd0;
    tick();
  endtask

  task automatic test_invalid_winner();
    logic [36:0] exp_v;
    set_cfg(2, 12, 88, 0, 0, 3);
    view_m = 3'd2;
    tick();
    for (int k = 0; k < 60; k++) begin
      tick();
      model(k, 1'b0, exp_v);
      n_cmp++;
      if (obs_m !== exp_v) begin
        n_fail++; $display("FAIL bad_winner k=%0d got %h want %h", k, obs_m, exp_v);
      end
    end
    view_m = 3'd0;
    tick();
  endtask

  task automatic test_abort();
    logic [36:0] exp_v;
    set_cfg(2, 41, 63, 0, 0, 2);
    view_m = 3'd2;
    tick();
    for (int k = 0; k < 30; k++) begin
      tick();
      model(k, 1'b0, exp_v);
      n_cmp++;
      if (obs_m !== exp_v) begin
        n_fail++; $display("FAIL abort_pre k=%0d got %h want %h", k, obs_m, exp_v);
      end
    end
    view_m = 3'd1;   // player 2, pos 2
    tick();
    n_cmp++;
    if (obs_m !== IDLE_VEC) begin
      n_fail++; $display("FAIL abort_blank got %h want %h", obs_m, IDLE_VEC);
    end
    view_m = 3'd2;
    tick();
    for (int k = 0; k < 45; k++) begin
      tick();
      model(k, 1'b0, exp_v);
      n_cmp++;
      if (obs_m !== exp_v) begin
        n_fail++; $display("FAIL abort_restart k=%0d got %h want %h", k, obs_m, exp_v);
      end
    end
    view_m = 3'd0;
    tick();
    // Reset in the middle of a scroll.
    view_m = 3'd2;
    tick();
    for (int k = 0; k < 10; k++) tick();
    rst_m = 1'b1;
    tick();
    n_cmp++;
    if (obs_m !== IDLE_VEC) begin
      n_fail++; $display("FAIL rst_midscroll got %h want %h", obs_m, IDLE_VEC);
    end
    rst_m = 1'b0;
    tick();
    for (int k = 0; k < 12; k++) begin
      tick();
      model(k, 1'b0, exp_v);
      n_cmp++;
      if (obs_m !== exp_v) begin
        n_fail++; $display("FAIL rst_restart k=%0d got %h want %h", k, obs_m, exp_v);
      end
    end
    view_m = 3'd0;
    tick();
  endtask

  task automatic test_loop();
    logic [36:0] exp_v;
    int period, stop_k;
    set_cfg(3, int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
            int'($urandom_range(0, 127)), 0, 2);
    period = 3 * 5 * STEP + HOLD_L * STEP;
    stop_k = period + 3 * 5 * STEP + 3;   // inside the second WIN hold
    view_l = 3'd2;
    tick();
    for (int k = 0; k <= stop_k; k++) begin
      tick();
      model(k, 1'b1, exp_v);
      n_cmp++;
      if (obs_l !== exp_v) begin
        n_fail++; $display("FAIL loop k=%0d got %h want %h", k, obs_l, exp_v);
      end
    end
    rst_l = 1'b1;
    tick();
    n_cmp++;
    if (obs_l !== IDLE_VEC) begin
      n_fail++; $display("FAIL loop_rst_win got %h want %h", obs_l, IDLE_VEC);
    end
    rst_l = 1'b0;
    view_l = 3'd0;
    tick();
  endtask

  task automatic test_random();
    logic [36:0] exp_v;
    int eff;
    for (int it = 0; it < 8; it++) begin
      set_cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 127)),
              int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
              int'($urandom_range(0, 127)), int'($urandom_range(0, 7)));
      eff = (cfg_pc == 0) ? 1 : ((cfg_pc > 4) ? 4 : cfg_pc);
      view_m = 3'd2;
      tick();
      for (int k = 0; k < eff * 5 * STEP + 45; k++) begin
        tick();
        model(k, 1'b0, exp_v);
        n_cmp++;
        if (obs_m !== exp_v) begin
          n_fail++;
          $display("FAIL random it=%0d k=%0d got %h want %h", it, k, obs_m, exp_v);
        end
      end
      view_m = 3'd0;
      tick();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_m = 1'b1; rst_l = 1'b1;
    view_m = 3'd0; view_l = 3'd0;
    set_cfg(1, 0, 0, 0, 0, 1);
    test_reset();
    test_positions();
    test_saturation_clamp();
    test_invalid_winner();
    test_abort();
    test_loop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/score_scroll_view.md
# score_scroll_view

Parametrised end-of-game results view for the seven-segment display. While its view is selected, it scrolls each active player's index and score left to right across the digit row, one player after another. It then holds the winner's frame at the right edge, optionally blinking and optionally looping. It outputs per-digit hex codes, which the existing BCD-to-segment and digit-scan logic downstream turns into `seg_out`/`seg_en`.

## Interface
Parameters:
- `MAX_PLAYERS`, 4: maximum number of players; sets the width of the score bus.
- `SCORE_W`, 7: width of each score in bits.
- `NUM_DIGITS`, 8: number of display digits; must be ≥ 4.
- `STEP_CYCLES`, 10_000_000: clk cycles per scroll step (100 ms at 100 MHz).
- `VIEW_ID`, 2: value of `view` that activates this block.
- `LOOP`, 0: when 1, the sequence restarts after the winner hold.
- `WIN_HOLD_STEPS`, 30: steps the winner frame is held before a restart; only used when `LOOP`=1.

Ports (name, direction, width, meaning):
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `view` in 3: currently selected view.
- `player_count` in 3: number of active players.
- `scores` in MAX_PLAYERS*SCORE_W: player p (1-based) occupies bits [(p-1)*SCORE_W +: SCORE_W].
- `winner` in 3: winning player, 1-based.
- `disp_code` out 4*NUM_DIGITS: digit i (0 = leftmost) occupies bits [4i+3:4i]; code 4'hF means blank.
- `cur_player` out 3: player currently shown; 0 in IDLE.
- `busy` out 1: high in SHOW.
- `done` out 1: one-cycle pulse on entering WIN.

## Operation
- States are IDLE, SHOW and WIN.
- Reset, or `view`≠`VIEW_ID`, forces IDLE on the next edge from any state. In IDLE all digits are blank, `cur_player`=0, the step counter is 0, and `busy`=`done`=0.
- IDLE → SHOW on the first cycle with `view`==`VIEW_ID`. The block sets `cur_player`=1, `pos`=0, and latches score 1.
- Effective player count = `player_count` clamped to the range 1..MAX_PLAYERS; a value of 0 is treated as 1.
- Frame is 4 digits wide: [player index][blank][score tens][score units].
  - It is placed at digits pos..pos+3.
  - `pos` runs from 0 to NUM_DIGITS-4.
  - All other digits are blank.
- Displayed score = min(latched score, 99), split into tens and units.
- Each `pos` value is held for STEP_CYCLES cycles.
  - After the last position, the next player is shown: `cur_player`+1, `pos`=0, and that player's score is latched.
  - After the last player, the block enters WIN.
- Scores are sampled only at player entry. Changes during a frame are ignored.
- WIN frame: [winner][blank][tens][units] at `pos`=NUM_DIGITS-4, using that winner's score, sampled on WIN entry.
  - If `winner` is 0 or greater than the effective count, all four frame digits are blank.
- WIN with `LOOP`=0: the block stays in WIN until it leaves the view.
- WIN with `LOOP`=1: after WIN_HOLD_STEPS steps the block re-enters SHOW with player 1.

## Timing
- All outputs are registered and change one cycle after the state or counter update.
- Start-up: the first visible frame appears 2 cycles after `view` becomes VIEW_ID (1 cycle to leave IDLE, 1 output register).
- The step counter runs 0..STEP_CYCLES-1. At the terminal count it wraps to 0 and advances `pos` in the same cycle.
- Each player is shown for (NUM_DIGITS-3)*STEP_CYCLES cycles.
- `done` is high for exactly the cycle after the WIN transition. It also pulses again on each loop's WIN entry.
- If the view is exited and immediately re-entered, the full sequence restarts from player 1; no partial state is kept.
- If `rst` is asserted mid-scroll, outputs are blank on the cycle after the reset edge.

## Configuration
- Macro: `SCORE_VIEW_BLINK_EN`.
- Defined: in WIN, the whole frame alternates visible/blank every 5 steps, starting visible.
- Undefined: the WIN frame is steady. The blink counter and its logic are absent.

## Structure
- Package `score_view_pkg` contains:
  - the state enum (IDLE, SHOW, WIN);
  - `BLANK_CODE` = 4'hF;
  - the `SCORE_DISP_MAX` = 99 constant;
  - a function that splits a saturated score into tens and units.
- Sub-module `step_timer`: a parameterised STEP_CYCLES counter with synchronous clear, producing a 1-cycle `step` pulse.

## Test plan
Bench parameters: STEP_CYCLES=4, NUM_DIGITS=8.
- Positions: player_count=2, scores 37/5, winner=1, view set to 2.
  - Player 1 frames step through digits 0,2,3 → 1,3,4 → 2,4,5 → 3,5,6 → 4,6,7, showing codes 1,3,7, each for 4 cycles.
  - Player 2 then shows 2,0,5.
  - Then WIN shows 1,3,7 at digits 4,6,7, with `done` pulsing once.
- Saturation and clamp: score 120 displays 9,9. player_count=0 shows player 1 only, then WIN.
- Invalid winner: winner=3 with player_count=2 → WIN digits are all blank and `done` still pulses.
- Mid-scroll abort: `view` changes to 1 during player 2, pos 2 → all blank next cycle. Returning `view` to 2 restarts at player 1, pos 0.
- Loop and reset:
  - LOOP=1, WIN_HOLD_STEPS=2: 8 cycles after WIN entry the block is back in SHOW with player 1.
  - `rst` asserted in WIN → IDLE outputs on the next cycle.
- Blink: with SCORE_VIEW_BLINK_EN defined, the WIN frame is visible for 20 cycles, blank for 20, then visible again. Without the macro it stays steady.
